// File: rtl/rr_arbiter8_pkg.sv
// ---------------------------------------------------------------------------
// rr_arbiter8_pkg
// Shared definitions for the 8-way round-robin arbiter: requester count,
// index/counter widths, FSM state encoding, the default hold limit, and a
// one-hot to index helper used when a winner is recorded as the new pointer.
// ---------------------------------------------------------------------------
package rr_arbiter8_pkg;

  localparam int N_REQ            = 8;
  localparam int IDX_W            = $clog2(N_REQ);
  localparam int HOLD_W           = 8;
  localparam int MAX_HOLD_DEFAULT = 15;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Index of the set bit in a one-hot vector (0 when the vector is empty).
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter8_pick8.sv
// ---------------------------------------------------------------------------
// rr_pick8
// Combinational rotate-priority picker. Scans req starting one position after
// ptr (ptr+1, ptr+2, ... wrapping modulo 8, ptr itself last) and returns the
// first requester found as a one-hot vector.
//
// Ports
//   req  [7:0] in  : request lines
//   ptr  [2:0] in  : index of the most recently granted requester
//   pick [7:0] out : one-hot winner, all-zero when no request is pending
//   any        out : at least one request is pending
// ---------------------------------------------------------------------------
module rr_pick8
  import rr_arbiter8_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic             any
);

  logic [IDX_W-1:0] idx;
  logic             found;

  assign any = |req;

  // NOTE: every variable assigned in an always_comb gets a default at the top
  // of the block, so no path leaves it holding its old value (no latch).
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    // The index adder wraps naturally at IDX_W bits, giving the modulo-8 scan.
    for (int i = 1; i <= N_REQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// ---------------------------------------------------------------------------
// rr_arbiter8
// Eight-requester round-robin arbiter with a bounded grant hold time.
// A grant is issued one cycle after a request is seen in IDLE and held until
// the holder raises done, drops its request, or has held for MAX_HOLD cycles.
// Every release passes through IDLE, so consecutive grants are always
// separated by at least one cycle with gnt = 0.
//
// Ports
//   Clock          in  : rising-edge clock
//   Resetn         in  : asynchronous active-low reset
//   req      [7:0] in  : level-sensitive request lines
//   done           in  : current holder releases the grant (ignored in IDLE)
//   gnt      [7:0] out : registered grant, one-hot or zero
//   gnt_valid      out : registered, equals |gnt
//   timeout        out : registered one-cycle pulse after a forced release
// ---------------------------------------------------------------------------
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT  // legal range 1..255
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic             timeout
);

  state_e            state, state_d;
  logic [IDX_W-1:0]  ptr, ptr_d;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
  logic [N_REQ-1:0]  gnt_d;
  logic              gnt_valid_d;
  logic              timeout_d;

  logic [N_REQ-1:0]  pick;
  logic              any;
  logic              holder_req;
  logic              hold_limit;
  logic              release_now;

  rr_pick8 u_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick),
    .any  (any)
  );

  // In GRANT, ptr is the index of the current holder.
  assign holder_req  = req[ptr];
  assign hold_limit  = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign release_now = done || !holder_req || hold_limit;

  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    hold_cnt_d  = hold_cnt;
    gnt_d       = gnt;
    gnt_valid_d = gnt_valid;
    timeout_d   = 1'b0;

    unique case (state)
      IDLE: begin
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        if (any) begin
          gnt_d       = pick;
          gnt_valid_d = 1'b1;
          ptr_d       = onehot_to_idx(pick);
          hold_cnt_d  = '0;
          state_d     = GRANT;
        end
      end

      GRANT: begin
        if (release_now) begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          state_d     = IDLE;
          // Forced only when neither voluntary cause is present.
          timeout_d   = hold_limit && !done && holder_req;
        end else if (hold_cnt != '1) begin
          hold_cnt_d = hold_cnt + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= IDLE;
      ptr       <= IDX_W'(N_REQ - 1);  // requester 0 scans first after reset
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      hold_cnt  <= hold_cnt_d;
      gnt       <= gnt_d;
      gnt_valid <= gnt_valid_d;
      timeout   <= timeout_d;
    end
  end

endmodule
